// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: two-manager (Fetcher, LSU) to one-subordinate OBI arbiter.
// Round-robin selection, address phase locked until grant, and a 1-bit ID FIFO
// that steers each response back to the manager that issued the request.
// Optional: define OBI_ARB_PERF_EN to build saturating per-manager grant counters.
module obi_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic                  ls_we,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err_rvalid,
  output logic [15:0]           grant_cnt_if,
  output logic [15:0]           grant_cnt_ls
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

  // Manager IDs: 0 = Fetcher, 1 = LSU.
  logic                 rr_ptr_reg;
  logic                 lock_reg;
  logic                 locked_id_reg;
  logic                 err_rvalid_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     count_next;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [MAX_OUTST-1:0] id_fifo_reg;

  logic sel;
  logic fifo_full;
  logic fifo_empty;
  logic handshake;
  logic pop;
  logic head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign head       = id_fifo_reg[rd_ptr_reg];

  // Pick the manager that owns the address phase this cycle.
  always_comb begin
    sel = rr_ptr_reg;
    if (lock_reg)
      sel = locked_id_reg;
    else if (if_req && !ls_req)
      sel = 1'b0;
    else if (ls_req && !if_req)
      sel = 1'b1;
  end

  // A full FIFO blocks requests even if a pop happens this cycle; the request
  // reappears once the registered count has dropped. Held low during reset.
  assign mem_req   = (if_req | ls_req) & ~fifo_full & rst;
  assign handshake = mem_req & mem_gnt;
  assign mem_addr  = sel ? ls_addr : if_addr;
  assign mem_we    = sel & ls_we;
  assign mem_wdata = sel ? ls_wdata : '0;
  assign if_gnt    = handshake & ~sel;
  assign ls_gnt    = handshake & sel;

  // Responses are routed by the FIFO head with no added latency.
  assign pop        = mem_rvalid & ~fifo_empty;
  assign if_rvalid  = pop & ~head;
  assign ls_rvalid  = pop & head;
  assign if_rdata   = mem_rdata;
  assign ls_rdata   = mem_rdata;
  assign err_rvalid = err_rvalid_reg;

  // Arbitration state: round-robin pointer and the pending-address lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg    <= 1'b0;
      lock_reg      <= 1'b0;
      locked_id_reg <= 1'b0;
    end else if (handshake) begin
      rr_ptr_reg <= ~sel;
      lock_reg   <= 1'b0;
    end else if (mem_req) begin
      lock_reg      <= 1'b1;
      locked_id_reg <= sel;
    end
  end

  // Next occupancy of the ID FIFO.
  always_comb begin
    count_next = count_reg;
    if (handshake && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (pop && !handshake)
      count_next = count_reg - CNT_W'(1);
  end

  // ID FIFO pointers, occupancy and the sticky orphan-response flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      err_rvalid_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (handshake)
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (mem_rvalid && fifo_empty)
        err_rvalid_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUTST; gi++) begin : g_fifo
      // Each entry captures the granted manager ID when the write pointer hits it.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          id_fifo_reg[gi] <= 1'b0;
        else if (handshake && (wr_ptr_reg == PTR_W'(gi)))
          id_fifo_reg[gi] <= sel;
      end
    end
  endgenerate

`ifdef OBI_ARB_PERF_EN
  logic [15:0] grant_cnt_if_reg;
  logic [15:0] grant_cnt_ls_reg;

  // Saturating handshake counters per manager.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_if_reg <= '0;
      grant_cnt_ls_reg <= '0;
    end else if (handshake) begin
      if (!sel && grant_cnt_if_reg != 16'hFFFF)
        grant_cnt_if_reg <= grant_cnt_if_reg + 16'd1;
      if (sel && grant_cnt_ls_reg != 16'hFFFF)
        grant_cnt_ls_reg <= grant_cnt_ls_reg + 16'd1;
    end
  end

  assign grant_cnt_if = grant_cnt_if_reg;
  assign grant_cnt_ls = grant_cnt_ls_reg;
`else
  assign grant_cnt_if = '0;
  assign grant_cnt_ls = '0;
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Testbench for obi_mem_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_obi_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, err_rvalid;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   grant_cnt_if, grant_cnt_ls;

  int checks = 0;
  int errors = 0;

  obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_rvalid(err_rvalid), .grant_cnt_if(grant_cnt_if), .grant_cnt_ls(grant_cnt_ls)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Outstanding transactions as a queue of manager IDs (0=IF, 1=LS).
  bit          m_q[$];
  bit          m_prio;      // manager favoured on the next conflict
  bit          m_lock;      // an ungranted address phase is pending
  bit          m_lock_id;
  bit          m_err;
  int          m_cnt_if, m_cnt_ls;
  bit          e_req, e_win, e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  function automatic void model_clear();
    m_q.delete();
    m_prio = 0; m_lock = 0; m_lock_id = 0; m_err = 0;
    m_cnt_if = 0; m_cnt_ls = 0;
  endfunction

  function automatic void model_eval();
    e_req = (if_req || ls_req) && (m_q.size() < MO);
    if (m_lock)                 e_win = m_lock_id;
    else if (if_req && !ls_req) e_win = 0;
    else if (ls_req && !if_req) e_win = 1;
    else                        e_win = m_prio;
    e_if_gnt = e_req && mem_gnt && !e_win;
    e_ls_gnt = e_req && mem_gnt && e_win;
    e_addr   = e_win ? ls_addr : if_addr;
    e_we     = e_win ? ls_we : 1'b0;
    e_wdata  = e_win ? ls_wdata : '0;
    e_if_rv  = mem_rvalid && (m_q.size() > 0) && (m_q[0] == 0);
    e_ls_rv  = mem_rvalid && (m_q.size() > 0) && (m_q[0] == 1);
  endfunction

  function automatic void model_advance();
    if (mem_rvalid) begin
      if (m_q.size() == 0) m_err = 1;
      else void'(m_q.pop_front());
    end
    if (e_req && mem_gnt) begin
      m_q.push_back(e_win);
      m_prio = !e_win;
      m_lock = 0;
      if (e_win) m_cnt_ls = (m_cnt_ls < 65535) ? m_cnt_ls + 1 : m_cnt_ls;
      else       m_cnt_if = (m_cnt_if < 65535) ? m_cnt_if + 1 : m_cnt_if;
    end else if (e_req) begin
      m_lock = 1; m_lock_id = e_win;
    end
  endfunction

  task automatic idle_inputs();
    if_req = 0; ls_req = 0; ls_we = 0; mem_gnt = 0; mem_rvalid = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    model_clear();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 0;
    if_req = 1; ls_req = 1; mem_gnt = 1; mem_rvalid = 1;
    if_addr = 32'h0000_1000; ls_addr = 32'h0000_2000;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if ({if_gnt, ls_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt got=%b exp=00", {if_gnt, ls_gnt}); end
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got=%b exp=00", {if_rvalid, ls_rvalid}); end
    checks++; if (err_rvalid !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_rvalid); end
    checks++; if ({grant_cnt_if, grant_cnt_ls} !== 32'h0) begin errors++; $display("FAIL rst_cnt got=%h exp=0", {grant_cnt_if, grant_cnt_ls}); end
    // First conflict after reset goes to the Fetcher.
    rst = 1; mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL rst_first_sel got=%h exp=%h", mem_addr, 32'h0000_1000); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_release_req got=%b exp=1", mem_req); end
    $display("[reset] reset state checked, first conflict addr=%h", mem_addr);
  endtask

  task automatic test_fetch_only();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if_req = (k < 3); if_addr = 32'(4 * k); mem_gnt = 1;
      mem_rvalid = (k > 0); mem_rdata = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      checks++; if (if_gnt !== (k < 3)) begin errors++; $display("FAIL fetch_if_gnt k=%0d got=%b exp=%b", k, if_gnt, k < 3); end
      checks++; if (if_rvalid !== (k > 0)) begin errors++; $display("FAIL fetch_if_rvalid k=%0d got=%b exp=%b", k, if_rvalid, k > 0); end
      checks++; if ({ls_gnt, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL fetch_ls_quiet k=%0d got=%b exp=00", k, {ls_gnt, ls_rvalid}); end
      if (k < 3) begin
        checks++; if (mem_addr !== 32'(4 * k) || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_addr k=%0d got=%h/%b exp=%h/0", k, mem_addr, mem_we, 32'(4 * k)); end
      end
      if (k > 0) begin
        checks++; if (if_rdata !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL fetch_rdata k=%0d got=%h exp=%h", k, if_rdata, 32'hA000_0000 + 32'(k)); end
      end
      $display("[fetch] k=%0d if_gnt=%b if_rvalid=%b addr=%h", k, if_gnt, if_rvalid, mem_addr);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_alternate();
    bit exp_ls, prev_ls;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if_req = (k < 6); ls_req = (k < 6);
      if_addr = 32'h100 + 32'(4 * k); ls_addr = 32'h200 + 32'(4 * k);
      ls_we = (k % 4 == 1); ls_wdata = 32'h5000 + 32'(k);
      mem_gnt = 1; mem_rvalid = (k > 0);
      exp_ls = (k % 2 == 1); prev_ls = ((k - 1) % 2 == 1);
      @(negedge clk);
      checks++; if (if_gnt !== (k < 6 && !exp_ls)) begin errors++; $display("FAIL alt_if_gnt k=%0d got=%b exp=%b", k, if_gnt, k < 6 && !exp_ls); end
      checks++; if (ls_gnt !== (k < 6 && exp_ls)) begin errors++; $display("FAIL alt_ls_gnt k=%0d got=%b exp=%b", k, ls_gnt, k < 6 && exp_ls); end
      if (k < 6) begin
        checks++; if (mem_addr !== (exp_ls ? ls_addr : if_addr) || mem_we !== (exp_ls && ls_we)) begin
          errors++; $display("FAIL alt_addr k=%0d got=%h/%b exp=%h/%b", k, mem_addr, mem_we, exp_ls ? ls_addr : if_addr, exp_ls && ls_we); end
      end
      if (k > 0) begin
        checks++; if ({if_rvalid, ls_rvalid} !== {!prev_ls, prev_ls}) begin
          errors++; $display("FAIL alt_route k=%0d got=%b exp=%b", k, {if_rvalid, ls_rvalid}, {!prev_ls, prev_ls}); end
      end
      $display("[alternate] k=%0d if_gnt=%b ls_gnt=%b if_rv=%b ls_rv=%b", k, if_gnt, ls_gnt, if_rvalid, ls_rvalid);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_lock_hold();
    do_reset();
    ls_addr = 32'h10; ls_we = 1; ls_wdata = 32'hDEAD_BEEF; if_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      ls_req = (k < 4); if_req = (k >= 1 && k <= 4);
      mem_gnt = (k >= 3); mem_rvalid = (k >= 4);
      @(negedge clk);
      if (k < 4) begin
        checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL lock_hold k=%0d got=%h/%b/%h exp=00000010/1/deadbeef", k, mem_addr, mem_we, mem_wdata); end
        checks++; if ({if_gnt, ls_gnt} !== {1'b0, k == 3}) begin errors++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, {if_gnt, ls_gnt}, {1'b0, k == 3}); end
      end else if (k == 4) begin
        checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_wdata !== '0) begin
          errors++; $display("FAIL lock_next_if got=%b/%h/%b/%h exp=1/00000040/0/0", if_gnt, mem_addr, mem_we, mem_wdata); end
        checks++; if ({if_rvalid, ls_rvalid} !== 2'b01) begin errors++; $display("FAIL lock_ls_resp got=%b exp=01", {if_rvalid, ls_rvalid}); end
      end else begin
        checks++; if ({if_rvalid, ls_rvalid} !== 2'b10) begin errors++; $display("FAIL lock_if_resp got=%b exp=10", {if_rvalid, ls_rvalid}); end
      end
      $display("[lock] k=%0d addr=%h we=%b if_gnt=%b ls_gnt=%b", k, mem_addr, mem_we, if_gnt, ls_gnt);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_full();
    bit exp_req_t[7];
    exp_req_t = '{1, 1, 0, 0, 1, 0, 0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if_req = (k < 5); if_addr = 32'h300 + 32'(4 * k); mem_gnt = 1;
      mem_rvalid = (k == 3 || k == 5 || k == 6);
      @(negedge clk);
      checks++; if (mem_req !== exp_req_t[k] || if_gnt !== exp_req_t[k]) begin
        errors++; $display("FAIL full_req k=%0d got=%b/%b exp=%b", k, mem_req, if_gnt, exp_req_t[k]); end
      checks++; if (if_rvalid !== mem_rvalid) begin errors++; $display("FAIL full_rvalid k=%0d got=%b exp=%b", k, if_rvalid, mem_rvalid); end
      $display("[full] k=%0d mem_req=%b if_gnt=%b if_rvalid=%b", k, mem_req, if_gnt, if_rvalid);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_err_empty();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = (k == 0);
      @(negedge clk);
      checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL err_no_route k=%0d got=%b exp=00", k, {if_rvalid, ls_rvalid}); end
      checks++; if (err_rvalid !== (k > 0)) begin errors++; $display("FAIL err_sticky k=%0d got=%b exp=%b", k, err_rvalid, k > 0); end
      $display("[err] k=%0d err_rvalid=%b", k, err_rvalid);
      @(posedge clk); #1;
    end
    // Asynchronous reset clears the flag without waiting for a clock edge.
    if_req = 1; mem_gnt = 1; rst = 0;
    #1;
    checks++; if (err_rvalid !== 1'b0) begin errors++; $display("FAIL err_async_clear got=%b exp=0", err_rvalid); end
    checks++; if ({mem_req, if_gnt} !== 2'b00) begin errors++; $display("FAIL err_rst_req got=%b exp=00", {mem_req, if_gnt}); end
    @(posedge clk); #1 rst = 1;
    // Two transactions in flight, then reset: their late responses are orphans.
    repeat (2) @(posedge clk);
    #1 if_req = 0; rst = 0;
    @(posedge clk); #1 rst = 1;
    mem_rvalid = 1;
    @(negedge clk);
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL err_mid_route got=%b exp=00", {if_rvalid, ls_rvalid}); end
    @(posedge clk); #1 mem_rvalid = 0;
    @(negedge clk);
    checks++; if (err_rvalid !== 1'b1) begin errors++; $display("FAIL err_mid_flag got=%b exp=1", err_rvalid); end
    $display("[err] orphan response after mid-operation reset err_rvalid=%b", err_rvalid);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_counters();
    int exp_if, exp_ls;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if_req = (k < 8); ls_req = (k < 6); mem_gnt = 1; mem_rvalid = (k > 0);
      @(posedge clk); #1;
    end
    idle_inputs();
`ifdef OBI_ARB_PERF_EN
    exp_if = 5; exp_ls = 3;
`else
    exp_if = 0; exp_ls = 0;
`endif
    @(negedge clk);
    checks++; if (grant_cnt_if !== 16'(exp_if)) begin errors++; $display("FAIL cnt_if got=%0d exp=%0d", grant_cnt_if, exp_if); end
    checks++; if (grant_cnt_ls !== 16'(exp_ls)) begin errors++; $display("FAIL cnt_ls got=%0d exp=%0d", grant_cnt_ls, exp_ls); end
    $display("[counters] grant_cnt_if=%0d grant_cnt_ls=%0d", grant_cnt_if, grant_cnt_ls);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit if_hold, ls_hold;
    int drain, exp_if, exp_ls;
    do_reset();
    if_hold = 0; ls_hold = 0;
    for (int c = 0; c < 500; c++) begin
      // Managers keep a pending (ungranted) request stable, per OBI.
      if (!if_hold) begin if_req = ($urandom_range(0, 2) != 0); if_addr = {$urandom, 2'b00}; end
      if (!ls_hold) begin
        ls_req = ($urandom_range(0, 2) != 0); ls_addr = {$urandom, 2'b00};
        ls_we = $urandom_range(0, 1); ls_wdata = $urandom;
      end
      mem_gnt = ($urandom_range(0, 3) != 0);
      mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      model_eval();
      @(negedge clk);
      checks++; if (mem_req !== e_req) begin errors++; $display("FAIL rnd_mem_req c=%0d got=%b exp=%b", c, mem_req, e_req); end
      checks++; if ({if_gnt, ls_gnt} !== {e_if_gnt, e_ls_gnt}) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {if_gnt, ls_gnt}, {e_if_gnt, e_ls_gnt}); end
      checks++; if ({if_rvalid, ls_rvalid} !== {e_if_rv, e_ls_rv}) begin errors++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, {if_rvalid, ls_rvalid}, {e_if_rv, e_ls_rv}); end
      checks++; if (err_rvalid !== m_err) begin errors++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err_rvalid, m_err); end
      if (e_req) begin
        checks++; if (mem_addr !== e_addr || mem_we !== e_we || mem_wdata !== e_wdata) begin
          errors++; $display("FAIL rnd_addr c=%0d got=%h/%b/%h exp=%h/%b/%h", c, mem_addr, mem_we, mem_wdata, e_addr, e_we, e_wdata); end
      end
      if (mem_rvalid) begin
        checks++; if (if_rdata !== mem_rdata || ls_rdata !== mem_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h", c, if_rdata, ls_rdata, mem_rdata); end
      end
      if (e_req && mem_gnt)
        $display("[random] c=%0d grant %s addr=%h we=%b", c, e_win ? "LS" : "IF", e_addr, e_we);
      @(posedge clk);
      model_advance();
      if_hold = if_req && !e_if_gnt;
      ls_hold = ls_req && !e_ls_gnt;
      #1;
    end
    // Drain outstanding responses, bounded.
    if_req = 0; ls_req = 0; mem_gnt = 0;
    drain = 0;
    while (m_q.size() > 0 && drain < 10) begin
      mem_rvalid = 1;
      model_eval();
      @(negedge clk);
      checks++; if ({if_rvalid, ls_rvalid} !== {e_if_rv, e_ls_rv}) begin errors++; $display("FAIL rnd_drain got=%b exp=%b", {if_rvalid, ls_rvalid}, {e_if_rv, e_ls_rv}); end
      @(posedge clk);
      model_advance();
      #1 drain++;
    end
    checks++; if (m_q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout left=%0d exp=0", m_q.size()); end
    mem_rvalid = 0;
`ifdef OBI_ARB_PERF_EN
    exp_if = m_cnt_if; exp_ls = m_cnt_ls;
`else
    exp_if = 0; exp_ls = 0;
`endif
    @(negedge clk);
    checks++; if (grant_cnt_if !== 16'(exp_if) || grant_cnt_ls !== 16'(exp_ls)) begin
      errors++; $display("FAIL rnd_cnt got=%0d/%0d exp=%0d/%0d", grant_cnt_if, grant_cnt_ls, exp_if, exp_ls); end
    $display("[random] model handshakes IF=%0d LS=%0d", m_cnt_if, m_cnt_ls);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_clear();
    test_reset();
    @(posedge clk); #1;
    test_fetch_only();
    test_alternate();
    test_lock_hold();
    test_full();
    test_err_empty();
    test_counters();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
